// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes, FSM state codes and strobe record for the MNIST inference sequencer
package nn_pkg;
    localparam int N_PIXELS = 784;
    localparam int N_HIDDEN = 10;
    localparam int N_OUT    = 10;
    localparam int DATA_W   = 32;
    localparam int MEM_LAT  = 1;
    localparam int PIX_AW   = 12;
    localparam int NEU_AW   = 4;
    localparam int BL_W     = 12;
    localparam int CNT_W    = $clog2(N_PIXELS);

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_CLEAR  = 4'd1;
    localparam state_t S_BIAS1  = 4'd2;
    localparam state_t S_L1     = 4'd3;
    localparam state_t S_GAP1   = 4'd4;
    localparam state_t S_BIAS2  = 4'd5;
    localparam state_t S_L2     = 4'd6;
    localparam state_t S_GAP2   = 4'd7;
    localparam state_t S_ARGMAX = 4'd8;
    localparam state_t S_DONE   = 4'd9;

    // Issue-time strobes; delayed MEM_LAT cycles to line up with ROM data.
    typedef struct packed {
        logic              bias;
        logic              layer;
        logic [NEU_AW-1:0] bias_idx;
        logic              pix;
        logic              dig;
        logic [NEU_AW-1:0] hid;
    } strobe_t;

    // Terminal count per state. GAP2 runs one cycle longer than GAP1 so the
    // final layer-2 accumulate has settled before the scores are read.
    function automatic logic [CNT_W-1:0] last_count(input state_t s);
        case (s)
            S_BIAS1:  return CNT_W'(N_HIDDEN - 1);
            S_L1:     return CNT_W'(N_PIXELS - 1);
            S_GAP1:   return CNT_W'(MEM_LAT);
            S_BIAS2:  return CNT_W'(N_OUT - 1);
            S_L2:     return CNT_W'(N_HIDDEN - 1);
            S_GAP2:   return CNT_W'(MEM_LAT + 1);
            S_ARGMAX: return CNT_W'(N_OUT - 1);
            default:  return '0;
        endcase
    endfunction
endpackage

// File: rtl/argmax_unit.sv
// argmax_unit: sequential signed max/index tracker; ties keep the lowest index
// Ports: step_i/idx_i/value_i present one score per cycle (idx 0 restarts the search),
//        commit_i latches the running winner (including this cycle's score) into digit_o/max_o.
module argmax_unit
    import nn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step_i,
    input  logic [NEU_AW-1:0]        idx_i,
    input  logic signed [DATA_W-1:0] value_i,
    input  logic                     commit_i,
    output logic [NEU_AW-1:0]        digit_o,
    output logic signed [DATA_W-1:0] max_o
);
    logic signed [DATA_W-1:0] best_q, best_d, max_q;
    logic [NEU_AW-1:0]        idx_q, idx_d, digit_q;
    logic                     take;

    always_comb begin
        take   = idx_i == '0 || value_i > best_q;
        best_d = take ? value_i : best_q;
        idx_d  = take ? idx_i : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q  <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            max_q   <= '0;
        end else begin
            if (step_i) begin
                best_q <= best_d;
                idx_q  <= idx_d;
            end
            if (commit_i) begin
                digit_q <= idx_d;
                max_q   <= best_d;
            end
        end
    end

    assign digit_o = digit_q;
    assign max_o   = max_q;
endmodule

// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: runs one 784-10-10 MNIST inference per start and returns the argmax digit
// Ports: start/abort/busy/done handshake; acc_clear, bias_addr/bias_load/bias_layer,
//        pixel_addr/valid_pixel, layer1_addr/layer1_addr_delay/valid_digit drive the ROMs and
//        neuron arrays; digit_sel/digit_value read the scores; digit/digit_max hold the result.
module nn_inference_sequencer
    import nn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     acc_clear,
    output logic [PIX_AW-1:0]        pixel_addr,
    output logic [NEU_AW-1:0]        bias_addr,
    output logic [BL_W-1:0]          bias_load,
    output logic                     bias_layer,
    output logic                     valid_pixel,
    output logic [NEU_AW-1:0]        layer1_addr,
    output logic [NEU_AW-1:0]        layer1_addr_delay,
    output logic                     valid_digit,
    output logic [NEU_AW-1:0]        digit_sel,
    input  logic signed [DATA_W-1:0] digit_value,
    output logic [NEU_AW-1:0]        digit,
    output logic signed [DATA_W-1:0] digit_max
);
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    strobe_t                 issue, tail;
    strobe_t [MEM_LAT-1:0]   line_q;
    logic                    cancel, last, in_bias;

    assign cancel  = abort && state_q != S_IDLE;
    assign last    = cnt_q == last_count(state_q);
    assign in_bias = state_q == S_BIAS1 || state_q == S_BIAS2;

    // States are numbered in run order, so advancing is an increment.
    always_comb begin
        state_d = cancel ? S_IDLE :
                  state_q == S_IDLE ? (start ? S_CLEAR : S_IDLE) :
                  state_q == S_DONE ? S_IDLE :
                  last ? state_q + 4'd1 : state_q;
        cnt_d   = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        issue          = '0;
        issue.bias     = in_bias;
        issue.layer    = state_q == S_BIAS2;
        issue.bias_idx = in_bias ? cnt_q[NEU_AW-1:0] : '0;
        issue.pix      = state_q == S_L1;
        issue.dig      = state_q == S_L2;
        issue.hid      = state_q == S_L2 ? cnt_q[NEU_AW-1:0] : '0;
    end

    // ROM-latency delay line; flushed on abort so no stale strobe escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) line_q[i] <= cancel ? '0 : line_q[i-1];
            line_q[0] <= cancel ? '0 : issue;
        end
    end

    assign tail              = line_q[MEM_LAT-1];
    assign busy              = state_q != S_IDLE && state_q != S_DONE;
    assign done              = state_q == S_DONE;
    assign acc_clear         = state_q == S_CLEAR;
    assign pixel_addr        = state_q == S_L1 ? PIX_AW'(cnt_q) : '0;
    assign bias_addr         = issue.bias_idx;
    assign layer1_addr       = issue.hid;
    assign digit_sel         = state_q == S_ARGMAX ? cnt_q[NEU_AW-1:0] : '0;
    // Neuron k sits on bias_load bit k+1.
    assign bias_load         = tail.bias ? BL_W'(2) << tail.bias_idx : '0;
    assign bias_layer        = tail.bias & tail.layer;
    assign valid_pixel       = tail.pix;
    assign valid_digit       = tail.dig;
    assign layer1_addr_delay = tail.hid;

    argmax_unit u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_i   (state_q == S_ARGMAX),
        .idx_i    (digit_sel),
        .value_i  (digit_value),
        .commit_i (state_q == S_ARGMAX && last && !cancel),
        .digit_o  (digit),
        .max_o    (digit_max)
    );
endmodule
